// File: rtl/msk_g16mul_rnd_feeder.sv
// -----------------------------------------------------------------------------
// msk_g16mul_rnd_feeder
//
// Randomness feeder sitting directly in front of the HPC1 G(16) masked
// multiplier. Fresh PRNG words are buffered in a small circular FIFO and each
// accepted operation consumes exactly one word:
//   - low 4*REF_N_RND bits drive the refresh randomness in the issue cycle,
//   - upper 4*DOM_RND bits are delayed 1+REF_RNDLAT cycles for the DOM lanes,
//   - res_valid marks the multiplier output, 2+REF_RNDLAT cycles after issue.
// A word is popped when it is used, so no random bit is ever used twice, and
// every random output is zero in cycles that carry no operation.
//
// Ports
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   prng_data    fresh random word, refresh part in the low bits
//   prng_valid   prng_data valid
//   prng_ready   buffer can accept a word this cycle (depends on state only)
//   op_valid     upstream requests an issue this cycle
//   op_ready     a buffered word is available; issue = op_valid && op_ready
//   rnd_ref      refresh randomness to the multiplier (issue cycle)
//   rnd_mul      DOM randomness to the multiplier (issue + 1 + REF_RNDLAT)
//   res_valid    multiplier outputs valid (issue + 2 + REF_RNDLAT)
//   fill         number of buffered words, 0..DEPTH
//   starve_cnt   saturating count of cycles with op_valid && !op_ready
// -----------------------------------------------------------------------------
module msk_g16mul_rnd_feeder #(
  parameter int d          = 2,
  parameter int REF_N_RND  = 1,
  parameter int DOM_RND    = 1,
  parameter int REF_RNDLAT = 1,
  parameter int DEPTH      = 4,
  parameter int RW         = 4*REF_N_RND + 4*DOM_RND
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [RW-1:0]                prng_data,
  input  logic                         prng_valid,
  output logic                         prng_ready,
  input  logic                         op_valid,
  output logic                         op_ready,
  output logic [4*REF_N_RND-1:0]       rnd_ref,
  output logic [4*DOM_RND-1:0]         rnd_mul,
  output logic                         res_valid,
  output logic [$clog2(DEPTH+1)-1:0]   fill,
  output logic [7:0]                   starve_cnt
);

  localparam int RR  = 4*REF_N_RND;              // refresh bits per word
  localparam int DW  = 4*DOM_RND;                // DOM bits per word
  localparam int LAT = 1 + REF_RNDLAT;           // DOM delay-line stages
  localparam int FW  = $clog2(DEPTH+1);
  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [FW-1:0] FILL_FULL = FW'(DEPTH);
  localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH-1);

  if (DEPTH < 2 || d < 2) begin : g_param_check
    $error("msk_g16mul_rnd_feeder: DEPTH and d must both be at least 2");
  end

  // ---------------------------------------------------------------------------
  // Word buffer
  // ---------------------------------------------------------------------------
  logic [RW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FW-1:0] fill_q,   fill_d;
  logic [7:0]    starve_q, starve_d;
  logic          push, issue;
  logic [RW-1:0] head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  // Both handshakes look only at the registered fill, so a word pushed this
  // cycle cannot be issued before the next one and prng_ready never depends
  // on op_valid.
  assign prng_ready = (fill_q != FILL_FULL);
  assign op_ready   = (fill_q != '0);
  assign push       = prng_valid && prng_ready;
  assign issue      = op_valid && op_ready;
  assign head       = mem_q[rd_ptr_q];

  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    starve_d = starve_q;

    if (push)  wr_ptr_d = ptr_inc(wr_ptr_q);
    if (issue) rd_ptr_d = ptr_inc(rd_ptr_q);

    unique case ({push, issue})
      2'b10:   fill_d = fill_q + FW'(1);
      2'b01:   fill_d = fill_q - FW'(1);
      default: fill_d = fill_q;
    endcase

    // A rejected request changes nothing except this counter.
    if (op_valid && !op_ready && starve_q != 8'hFF) starve_d = starve_q + 8'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      starve_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      starve_q <= starve_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; a slot is only read
  // after it has been written, and fill/pointers alone define emptiness.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= prng_data;
  end

  // ---------------------------------------------------------------------------
  // Randomness routing
  // ---------------------------------------------------------------------------
  // Refresh bits leave combinationally in the issue cycle, zero otherwise.
  assign rnd_ref = issue ? head[RR-1:0] : '0;

  // DOM bits travel with a valid flag; empty stages hold zero so rnd_mul is
  // zero whenever its stage carries no operation.
  logic [DW-1:0]  dom_q [LAT];
  logic [LAT-1:0] vld_q;
  logic           res_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LAT; k++) dom_q[k] <= '0;
      vld_q       <= '0;
      res_valid_q <= 1'b0;
    end else begin
      dom_q[0] <= issue ? head[RW-1:RR] : '0;
      vld_q[0] <= issue;
      for (int k = 1; k < LAT; k++) begin
        dom_q[k] <= dom_q[k-1];
        vld_q[k] <= vld_q[k-1];
      end
      res_valid_q <= vld_q[LAT-1];
    end
  end

  assign rnd_mul    = dom_q[LAT-1];
  assign res_valid  = res_valid_q;
  assign fill       = fill_q;
  assign starve_cnt = starve_q;

endmodule

// File: tb/tb_msk_g16mul_rnd_feeder.sv
// -----------------------------------------------------------------------------
// Testbench for msk_g16mul_rnd_feeder (default parameters, RW = 8).
// The reference model keeps the buffered words in a queue and schedules the
// DOM nibble and result flag by absolute cycle number (issue + 2 / issue + 3).
// Inputs change just after the falling edge; outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_msk_g16mul_rnd_feeder;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] prng_data = '0;
  logic       prng_valid = 1'b0;
  logic       prng_ready;
  logic       op_valid = 1'b0;
  logic       op_ready;
  logic [3:0] rnd_ref;
  logic [3:0] rnd_mul;
  logic       res_valid;
  logic [2:0] fill;
  logic [7:0] starve_cnt;

  msk_g16mul_rnd_feeder #(
    .d(2), .REF_N_RND(1), .DOM_RND(1), .REF_RNDLAT(1), .DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .prng_data  (prng_data),
    .prng_valid (prng_valid),
    .prng_ready (prng_ready),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .rnd_ref    (rnd_ref),
    .rnd_mul    (rnd_mul),
    .res_valid  (res_valid),
    .fill       (fill),
    .starve_cnt (starve_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  logic [7:0] mq[$];             // buffered words, oldest first
  logic [3:0] mul_at[int];       // DOM nibble due at cycle
  bit         res_at[int];       // result valid due at cycle
  int         cyc = 0;
  int         starve_m = 0;

  bit         e_pready, e_oready, e_res;
  logic [3:0] e_ref, e_mul;
  logic [2:0] e_fill;
  logic [7:0] e_starve;

  // One clock cycle: drive inputs, compute what the outputs must be in this
  // cycle, then advance the model across the coming rising edge.
  task automatic step(input bit pv, input logic [7:0] pd, input bit ov);
    bit iss;
    @(negedge clk);
    prng_valid = pv; prng_data = pd; op_valid = ov;
    #1;
    e_pready = (mq.size() < DEPTH);
    e_oready = (mq.size() > 0);
    e_fill   = 3'(mq.size());
    iss      = ov && e_oready;
    e_ref    = iss ? mq[0][3:0] : 4'h0;
    e_mul    = mul_at.exists(cyc) ? mul_at[cyc] : 4'h0;
    e_res    = res_at.exists(cyc);
    e_starve = 8'(starve_m);
    if (ov && !e_oready && starve_m < 255) starve_m++;
    if (iss) begin
      mul_at[cyc + 2] = mq[0][7:4];
      res_at[cyc + 3] = 1'b1;
      void'(mq.pop_front());
    end
    if (pv && e_pready) mq.push_back(pd);
    cyc++;
  endtask

  task automatic assert_reset();
    @(negedge clk);
    rst_n = 1'b0; prng_valid = 1'b0; op_valid = 1'b0; prng_data = '0;
    #1;
    mq.delete(); mul_at.delete(); res_at.delete(); starve_m = 0;
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    assert_reset();
    release_reset();
    step(0, 8'h00, 0);
    total++; if (prng_ready !== 1'b1) begin bad++; $display("FAIL reset_prng_ready got=%b exp=1", prng_ready); end
    total++; if (op_ready !== 1'b0)   begin bad++; $display("FAIL reset_op_ready got=%b exp=0", op_ready); end
    total++; if (fill !== 3'd0)       begin bad++; $display("FAIL reset_fill got=%0d exp=0", fill); end
    total++; if (rnd_ref !== 4'h0)    begin bad++; $display("FAIL reset_rnd_ref got=%h exp=0", rnd_ref); end
    total++; if (rnd_mul !== 4'h0)    begin bad++; $display("FAIL reset_rnd_mul got=%h exp=0", rnd_mul); end
    total++; if (res_valid !== 1'b0)  begin bad++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
    total++; if (starve_cnt !== 8'd0) begin bad++; $display("FAIL reset_starve got=%0d exp=0", starve_cnt); end
  endtask

  task automatic test_basic();
    logic [7:0] pd [8] = '{8'hA5, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    bit         pv [8] = '{1, 1, 0, 0, 0, 0, 0, 0};
    bit         ov [8] = '{0, 0, 1, 1, 0, 0, 0, 0};
    // Hand-derived expectations: issues at steps 2,3 -> dom at 4,5, res at 5,6.
    logic [3:0] x_ref [8] = '{4'h0, 4'h0, 4'h5, 4'hC, 4'h0, 4'h0, 4'h0, 4'h0};
    logic [3:0] x_mul [8] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'hA, 4'h3, 4'h0, 4'h0};
    bit         x_res [8] = '{0, 0, 0, 0, 0, 1, 1, 0};
    logic [2:0] x_fil [8] = '{3'd0, 3'd1, 3'd2, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0};
    assert_reset();
    release_reset();
    for (int i = 0; i < 8; i++) begin
      step(pv[i], pd[i], ov[i]);
      total++; if (rnd_ref !== x_ref[i])   begin bad++; $display("FAIL basic_ref step=%0d got=%h exp=%h", i, rnd_ref, x_ref[i]); end
      total++; if (rnd_mul !== x_mul[i])   begin bad++; $display("FAIL basic_mul step=%0d got=%h exp=%h", i, rnd_mul, x_mul[i]); end
      total++; if (res_valid !== x_res[i]) begin bad++; $display("FAIL basic_res step=%0d got=%b exp=%b", i, res_valid, x_res[i]); end
      total++; if (fill !== x_fil[i])      begin bad++; $display("FAIL basic_fill step=%0d got=%0d exp=%0d", i, fill, x_fil[i]); end
    end
  endtask

  task automatic test_full();
    assert_reset();
    release_reset();
    for (int i = 0; i < 4; i++) step(1, 8'($urandom), 0);
    // fifth word offered at full: must be refused
    step(1, 8'hEE, 0);
    total++; if (fill !== 3'd4)        begin bad++; $display("FAIL full_fill got=%0d exp=4", fill); end
    total++; if (prng_ready !== 1'b0)  begin bad++; $display("FAIL full_prng_ready got=%b exp=0", prng_ready); end
    // pop at full while still offering a word: the word is still refused
    step(1, 8'hEF, 1);
    total++; if (prng_ready !== 1'b0)  begin bad++; $display("FAIL full_pop_ready got=%b exp=0", prng_ready); end
    total++; if (rnd_ref !== e_ref)    begin bad++; $display("FAIL full_pop_ref got=%h exp=%h", rnd_ref, e_ref); end
    step(0, 8'h00, 0);
    total++; if (prng_ready !== 1'b1)  begin bad++; $display("FAIL full_freed_ready got=%b exp=1", prng_ready); end
    total++; if (fill !== 3'd3)        begin bad++; $display("FAIL full_freed_fill got=%0d exp=3", fill); end
    // drain: the three remaining words come out in order
    for (int i = 0; i < 7; i++) begin
      step(0, 8'h00, 1);
      total++; if (rnd_ref !== e_ref)  begin bad++; $display("FAIL full_drain_ref i=%0d got=%h exp=%h", i, rnd_ref, e_ref); end
      total++; if (rnd_mul !== e_mul)  begin bad++; $display("FAIL full_drain_mul i=%0d got=%h exp=%h", i, rnd_mul, e_mul); end
      total++; if (fill !== e_fill)    begin bad++; $display("FAIL full_drain_fill i=%0d got=%0d exp=%0d", i, fill, e_fill); end
    end
  endtask

  task automatic test_starve();
    assert_reset();
    release_reset();
    for (int i = 0; i < 300; i++) begin
      step(0, 8'h00, 1);
      total++; if (op_ready !== 1'b0 || res_valid !== 1'b0) begin
        bad++; $display("FAIL starve_idle i=%0d op_ready=%b res_valid=%b exp=0/0", i, op_ready, res_valid);
      end
      total++; if (starve_cnt !== e_starve) begin bad++; $display("FAIL starve_cnt i=%0d got=%0d exp=%0d", i, starve_cnt, e_starve); end
    end
    step(0, 8'h00, 1);
    total++; if (starve_cnt !== 8'd255) begin bad++; $display("FAIL starve_sat got=%0d exp=255", starve_cnt); end
    step(0, 8'h00, 0);
    total++; if (starve_cnt !== 8'd255) begin bad++; $display("FAIL starve_hold got=%0d exp=255", starve_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] seen_ref[$];
    logic [3:0] seen_mul[$];
    int         res_run = 0;
    assert_reset();
    release_reset();
    step(1, 8'h00, 0);
    for (int i = 1; i <= 64; i++) begin
      step(i < 64, 8'(i), 1);
      seen_ref.push_back(rnd_ref);
      total++; if (fill !== 3'd1)     begin bad++; $display("FAIL b2b_fill i=%0d got=%0d exp=1", i, fill); end
      total++; if (rnd_ref !== e_ref) begin bad++; $display("FAIL b2b_ref i=%0d got=%h exp=%h", i, rnd_ref, e_ref); end
      if (i >= 3) seen_mul.push_back(rnd_mul);
      if (i >= 4 && res_valid === 1'b1) res_run++;
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 8'h00, 0);
      if (i < 2) seen_mul.push_back(rnd_mul);
      if (i < 3 && res_valid === 1'b1) res_run++;
    end
    // words 0x00..0x3F: refresh nibble = i[3:0], DOM nibble = i[7:4], in order
    for (int i = 0; i < 64; i++) begin
      total++; if (seen_ref[i] !== 4'(i))      begin bad++; $display("FAIL b2b_ref_order i=%0d got=%h exp=%h", i, seen_ref[i], 4'(i)); end
      total++; if (seen_mul[i] !== 4'(i >> 4)) begin bad++; $display("FAIL b2b_mul_order i=%0d got=%h exp=%h", i, seen_mul[i], 4'(i >> 4)); end
    end
    total++; if (res_run != 64) begin bad++; $display("FAIL b2b_res_count got=%0d exp=64", res_run); end
  endtask

  task automatic test_reset_mid();
    assert_reset();
    release_reset();
    step(1, 8'h96, 0);
    step(1, 8'h47, 0);
    step(0, 8'h00, 1);
    step(0, 8'h00, 1);
    assert_reset();   // cycle in which the first DOM nibble (0x9) would appear
    total++; if (rnd_mul !== 4'h0)   begin bad++; $display("FAIL rstmid_mul got=%h exp=0", rnd_mul); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL rstmid_res got=%b exp=0", res_valid); end
    total++; if (fill !== 3'd0)      begin bad++; $display("FAIL rstmid_fill got=%0d exp=0", fill); end
    release_reset();
    for (int i = 0; i < 6; i++) begin
      step(0, 8'h00, 0);
      total++; if (res_valid !== 1'b0 || rnd_mul !== 4'h0) begin
        bad++; $display("FAIL rstmid_after i=%0d res_valid=%b rnd_mul=%h exp=0/0", i, res_valid, rnd_mul);
      end
    end
  endtask

  task automatic test_no_bypass();
    assert_reset();
    release_reset();
    step(1, 8'h7B, 1);
    total++; if (op_ready !== 1'b0) begin bad++; $display("FAIL nobyp_op_ready got=%b exp=0", op_ready); end
    total++; if (rnd_ref !== 4'h0)  begin bad++; $display("FAIL nobyp_ref0 got=%h exp=0", rnd_ref); end
    step(0, 8'h00, 1);
    total++; if (starve_cnt !== 8'd1) begin bad++; $display("FAIL nobyp_starve got=%0d exp=1", starve_cnt); end
    total++; if (rnd_ref !== 4'hB)    begin bad++; $display("FAIL nobyp_ref1 got=%h exp=b", rnd_ref); end
    step(0, 8'h00, 0);
    step(0, 8'h00, 0);
    total++; if (rnd_mul !== 4'h7)    begin bad++; $display("FAIL nobyp_mul got=%h exp=7", rnd_mul); end
  endtask

  task automatic test_random();
    assert_reset();
    release_reset();
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0);
      total++; if (prng_ready !== e_pready) begin bad++; $display("FAIL rnd_prng_ready i=%0d got=%b exp=%b", i, prng_ready, e_pready); end
      total++; if (op_ready !== e_oready)   begin bad++; $display("FAIL rnd_op_ready i=%0d got=%b exp=%b", i, op_ready, e_oready); end
      total++; if (fill !== e_fill)         begin bad++; $display("FAIL rnd_fill i=%0d got=%0d exp=%0d", i, fill, e_fill); end
      total++; if (rnd_ref !== e_ref)       begin bad++; $display("FAIL rnd_ref i=%0d got=%h exp=%h", i, rnd_ref, e_ref); end
      total++; if (rnd_mul !== e_mul)       begin bad++; $display("FAIL rnd_mul i=%0d got=%h exp=%h", i, rnd_mul, e_mul); end
      total++; if (res_valid !== e_res)     begin bad++; $display("FAIL rnd_res i=%0d got=%b exp=%b", i, res_valid, e_res); end
      total++; if (starve_cnt !== e_starve) begin bad++; $display("FAIL rnd_starve i=%0d got=%0d exp=%0d", i, starve_cnt, e_starve); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_starve();
    test_back_to_back();
    test_reset_mid();
    test_no_bypass();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/msk_g16mul_rnd_feeder.md
Name: msk_g16mul_rnd_feeder

Overview:
- Randomness-feeding stage directly upstream of the HPC1 G(16) masked multiplier.
- Buffers fresh words from the PRNG and issues one G(16) multiplication per accepted operation.
- Drives the multiplier's refresh randomness in the issue cycle and its DOM randomness exactly 1+REF_RNDLAT cycles later.
- Produces a result-valid flag aligned with the multiplier output (2+REF_RNDLAT cycles after issue).
- Guarantees that no random bit is ever used twice.

Parameters:
- d, 2, number of shares (passed through for width consistency; not used in datapath).
- REF_N_RND, 1, random bits per SNI refresh instance (four instances per multiplication).
- DOM_RND, 1, random bits per DOM nibble lane (four lanes per multiplication).
- REF_RNDLAT, 1, latency in cycles of the SNI refresh stage.
- DEPTH, 4, PRNG word buffer depth in words (≥2).
- RW, 4*REF_N_RND+4*DOM_RND, derived: PRNG word width.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- prng_data  input  RW  fresh random word; bits [4*REF_N_RND-1:0] are the refresh part, the upper bits are the DOM part.
- prng_valid  input  1  prng_data valid.
- prng_ready  output  1  buffer accepts a word this cycle.
- op_valid  input  1  upstream presents inb shares this cycle and requests issue.
- op_ready  output  1  a word is available; an operation issues when op_valid&&op_ready.
- rnd_ref  output  4*REF_N_RND  to multiplier rnd_ref.
- rnd_mul  output  4*DOM_RND  to multiplier rnd_mul.
- res_valid  output  1  multiplier out0..out3 valid this cycle.
- fill  output  $clog2(DEPTH+1)  words currently buffered.
- starve_cnt  output  8  saturating count of cycles with op_valid&&!op_ready.

Behaviour:
- Reset (async assert, sync release): buffer empty, fill=0, prng_ready=1, op_ready=0, rnd_ref=0, rnd_mul=0, res_valid=0, starve_cnt=0, all delay-line stages cleared. Reset mid-operation drops all in-flight operations; no res_valid is produced for them.
- Buffer:
  - Circular FIFO, DEPTH words; read/write pointers wrap modulo DEPTH.
  - prng_ready = (fill<DEPTH), registered-equivalent; no combinational dependence on op_valid.
  - Push on prng_valid&&prng_ready.
- Issue:
  - op_ready = (fill>0). No bypass: a word pushed in cycle t is first usable in cycle t+1.
  - Issue pops the head word.
  - Refresh part is driven on rnd_ref in the same cycle (combinational from head, gated by issue).
  - DOM part enters a delay line of 1+REF_RNDLAT registers.
- Outputs when idle:
  - rnd_ref=0 in any cycle without issue.
  - rnd_mul=0 in any cycle whose corresponding delay stage is empty.
  - Random words are never replicated or held.
- Timing: issue at cycle t ⇒ rnd_ref at t, rnd_mul at t+1+REF_RNDLAT, res_valid high for exactly cycle t+2+REF_RNDLAT. Back-to-back issues are fully pipelined (one per cycle, no stall).
- Simultaneous push and pop:
  - fill unchanged; allowed even when fill==DEPTH only if prng_ready was already 1 (i.e. never at full).
  - At full, a pop frees the slot from the next cycle.
- fill range 0..DEPTH; must never under/overflow.
- starve_cnt increments each cycle with op_valid&&!op_ready and saturates at 255.
- op_valid with op_ready=0 is a dropped request: no state change besides starve_cnt. Upstream must hold or retry.

Test Plan:
- Reset then push words 0xA5,0x3C (RW=8) on consecutive cycles, issue at cycle 4 and 5 → rnd_ref=0x5 then 0xC at cycles 4,5; rnd_mul=0xA at 6, 0x3 at 7; res_valid at 7,8; fill 2→0.
- Push 4 words with no issue → fill=4, prng_ready=0; a fifth prng_valid is not accepted; issue once → prng_ready=1 next cycle, fill=3.
- Empty buffer, op_valid held 300 cycles → op_ready=0, no res_valid, starve_cnt saturates at 255 and stays.
- Steady state: push and issue every cycle with distinct words 0x00..0x3F → each refresh/DOM nibble appears exactly once in order; fill constant; res_valid continuous.
- Assert rst_n low one cycle after two issues → rnd_mul and res_valid forced 0 immediately, fill=0; no res_valid after release.
- Push at cycle t into empty buffer with op_valid at t → no issue at t (op_ready=0, starve_cnt=1); issue at t+1.
